// File: rtl/demux_dist_if.sv
// Handshake bundle for the 1-to-N distributor: upstream word channel plus
// per-destination valid/ready with a shared data bus.
interface demux_dist_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic [SEL_W-1:0]    in_sel;
    logic                in_bcast;
    logic [WIDTH-1:0]    out_data;
    logic [CHANNELS-1:0] out_valid;
    logic [CHANNELS-1:0] out_ready;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_dist.sv
// Registered 1-to-N word distributor: one selected channel or broadcast,
// with out-of-range drop reporting and a saturating drop counter.
module demux_dist #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    demux_dist_if.slave      bus,
    output logic             err,
    output logic [CNT_W-1:0] drop_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] p_q, p_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                err_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                ready;
    logic                accept;
    logic                in_range;

    // Ready as soon as every still-pending channel completes this cycle.
    assign ready         = (state_q == IDLE) || ((p_q & ~bus.out_ready) == '0);
    assign bus.in_ready  = ready;
    assign bus.out_valid = p_q;
    assign bus.out_data  = data_q;

    always_comb begin
        p_d      = p_q & ~bus.out_ready;
        data_d   = data_q;
        err_d    = 1'b0;
        cnt_d    = drop_cnt;
        accept   = bus.in_valid && ready;
        in_range = int'(bus.in_sel) < CHANNELS;
        if (accept) begin
            if (bus.in_bcast) begin
                p_d    = '1;
                data_d = bus.in_data;
            end else if (in_range) begin
                p_d    = ONE << bus.in_sel;
                data_d = bus.in_data;
            end else begin
                p_d   = '0;
                err_d = 1'b1;
                if (drop_cnt != '1)
                    cnt_d = drop_cnt + 1'b1;
            end
        end
        state_d = (p_d == '0) ? IDLE : HOLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            data_q   <= '0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            data_q   <= data_d;
            err      <= err_d;
            drop_cnt <= cnt_d;
        end
    end
endmodule
